srl_delay_line: RTL and testbench
=================================

// Module: srl_delay_line
// PURPOSE
//   Multi-channel delay line with a runtime-programmable depth. Tracks valid alongside data and supports clock-enable stalls.
//   Successor to the fixed-depth SRL delay; used to align feature/weight streams whose pipeline skew varies per layer config.
//   Sits between datapath stages; the delay is reprogrammed by the layer controller between layers.
// PARAMETERS
//   C_DATA_WIDTH    32  bits per channel
//   C_NUM_CHANNELS  1   independent lanes sharing one delay setting and one valid
//   C_MAX_DELAY     16  maximum programmable delay in ce-cycles (>=1)
//   C_RESET_DELAY   1   delay in effect after reset (0..C_MAX_DELAY)
//   C_DLY_W         $clog2(C_MAX_DELAY+1), derived; do not override
// PORTS
//   clk        in   1                            clock
//   rst        in   1                            synchronous, active-high reset
//   ce         in   1                            shift enable; stall when low
//   cfg_load   in   1                            request new delay (accepted when cfg_busy=0)
//   delay_cfg  in   C_DLY_W                      requested delay, sampled with cfg_load
//   cfg_busy   out  1                            high during the LOAD cycle; cfg_load is ignored then
//   cfg_err    out  1                            1-cycle pulse: delay_cfg>C_MAX_DELAY, clamped
//   primed     out  1                            pipe holds `delay` ce-cycles of post-config history
//   valid_in   in   1                            input qualifier
//   data_in    in   C_NUM_CHANNELS*C_DATA_WIDTH  channel k at [k*C_DATA_WIDTH +: C_DATA_WIDTH]
//   valid_out  out  1                            delayed valid
//   data_out   out  C_NUM_CHANNELS*C_DATA_WIDTH  delayed data, same packing
// BEHAVIOUR
//   Reset: delay_q=C_RESET_DELAY, all stage valid/data=0, state=FILL, fill_cnt=0. Outputs: valid_out=0, data_out=0,
//     cfg_busy=0, cfg_err=0, primed=(C_RESET_DELAY==0). rst overrides every other input.
//   Pipe: C_MAX_DELAY stages of {valid,data}. On ce=1, stage0<=in and stage i<=stage i-1. On ce=0, hold.
//   Tap: delay_q>0 -> {valid_out,data_out}=stage[delay_q-1] (latency delay_q ce-cycles).
//     delay_q==0 -> combinational pass-through; valid_out=valid_in&~cfg_busy.
//   FSM states: FILL, RUN, LOAD.
//     FILL/RUN + cfg_load -> LOAD. Same edge: delay_q<=min(delay_cfg,C_MAX_DELAY); cfg_err<=(delay_cfg>C_MAX_DELAY).
//     LOAD (1 cycle, cfg_busy=1): clear every stage valid bit (data untouched), no shift regardless of ce,
//       fill_cnt<=0, and go to FILL; go to RUN instead if delay_q==0.
//     FILL: each ce cycle increments fill_cnt; fill_cnt==delay_q-1 with ce -> RUN.
//     RUN: primed=1; stays until next cfg_load.
//   primed = (state==RUN). valid_out is only trustworthy after primed, but cleared valids guarantee no stale data is reported.
//   cfg_load while cfg_busy=1: ignored, no error. Repeated cfg_load in FILL restarts the fill.
//   Shrinking or growing the delay always flushes; no data is carried across a reconfiguration.
//   cfg_load and ce in the same cycle: the shift still occurs that cycle; the flush happens in LOAD.
//   Reset mid-fill or mid-LOAD returns to post-reset state with C_RESET_DELAY.
// CONFIGURATION
//   SRL_DELAY_LINE_OUT_REG_EN defined: {valid_out,data_out} pass through one extra register, clocked on ce and
//     reset to 0, and cleared in LOAD. Latency is delay_q+1 (1 at delay_q=0, no combinational path).
//     primed asserts one ce-cycle later than without the macro.
//   Undefined: outputs driven directly from the tap mux as above.
// STRUCTURE
//   Package srl_delay_line_pkg: state enum {ST_FILL,ST_RUN,ST_LOAD}; function clog2 for C_DLY_W.
//   Sub-module srl_dyn_tap: one (1+C_NUM_CHANNELS*C_DATA_WIDTH)-bit-wide shift chain with ce, valid-clear and a
//     dynamic tap select. Top level holds the FSM, clamp logic, fill counter and the optional output register.
// TESTING
//   1 Reset, C_RESET_DELAY=1; valid_in=1, data=0xA5 for one ce cycle -> valid_out/data_out=0xA5 next cycle; primed after 1 ce.
//   2 cfg_load delay_cfg=5, then stream 0..9 with ce=1 -> cfg_busy is 1 for 1 cycle; output k appears 5 cycles after
//     input k; primed rises on 5th ce after LOAD.
//   3 delay=4 and ce toggled 1,0,1,0 while streaming -> output order is preserved and each item appears after exactly 4 ce-high edges.
//   4 delay_cfg=31 with C_MAX_DELAY=16 -> cfg_err pulses once and effective latency is 16.
//   5 cfg_load during FILL and while cfg_busy=1 -> second load is ignored while busy; a load during FILL restarts
//     fill_cnt; no stale valid_out=1 appears.
//   6 delay=0: valid_out==valid_in combinationally; with OUT_REG_EN latency is 1. rst mid-stream clears valid_out next cycle.

Source files
------------

// File: rtl/srl_delay_line_pkg.sv
// ---------------------------------------------------------------------------
// srl_delay_line_pkg
//   Shared types and helpers for the programmable-depth delay line.
//   - state_t : control FSM states (fill, run, reconfiguration load)
//   - clog2   : constant function used to size the delay select
// ---------------------------------------------------------------------------
package srl_delay_line_pkg;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/srl_dyn_tap.sv
// ---------------------------------------------------------------------------
// srl_dyn_tap
//   Shift chain of C_DEPTH stages, each C_WIDTH bits wide ({valid, data},
//   valid in the MSB), with a dynamic read tap.
//   Ports:
//     clk, rst     clock, synchronous active-high reset (clears all stages)
//     shift_en     advance the chain by one stage
//     clear_valid  zero every stage's valid bit, data untouched
//     din          value entering stage 0
//     sel          tap select; sel=k returns stage k-1, sel=0 returns 0
//     dout         selected stage
// ---------------------------------------------------------------------------
module srl_dyn_tap #(
    parameter int C_WIDTH = 33,
    parameter int C_DEPTH = 16,
    parameter int C_SEL_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift_en,
    input  logic               clear_valid,
    input  logic [C_WIDTH-1:0] din,
    input  logic [C_SEL_W-1:0] sel,
    output logic [C_WIDTH-1:0] dout
);

    logic [C_WIDTH-1:0] stage [C_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < C_DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else if (clear_valid) begin
            // Only the valid bits are dropped; stale data stays but can never
            // be reported as valid.
            for (int i = 0; i < C_DEPTH; i++) begin
                stage[i][C_WIDTH-1] <= 1'b0;
            end
        end else if (shift_en) begin
            stage[0] <= din;
            for (int i = 1; i < C_DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    // One-hot style compare keeps the mux free of out-of-range indexing.
    always_comb begin
        dout = '0;
        for (int i = 0; i < C_DEPTH; i++) begin
            if (sel == C_SEL_W'(i + 1)) begin
                dout = stage[i];
            end
        end
    end

endmodule

// File: rtl/srl_delay_line.sv
// ---------------------------------------------------------------------------
// srl_delay_line
//   Multi-channel delay line with runtime-programmable depth (0..C_MAX_DELAY
//   ce-cycles), valid tracking and clock-enable stalls. A reconfiguration
//   always flushes the pipe (valid bits cleared) and re-primes it.
//   Ports:
//     clk, rst    clock, synchronous active-high reset
//     ce          shift enable (stall when low)
//     cfg_load    request new delay, ignored while cfg_busy
//     delay_cfg   requested delay, clamped to C_MAX_DELAY
//     cfg_busy    high during the single LOAD cycle
//     cfg_err     one-cycle pulse when the request was clamped
//     primed      pipe holds `delay` ce-cycles of post-config history
//     valid_in, data_in    input qualifier and packed channel data
//     valid_out, data_out  delayed valid and data, same packing
//   Optional build macro SRL_DELAY_LINE_OUT_REG_EN: adds a ce-clocked output
//   register (latency delay+1, no combinational path at delay 0).
// ---------------------------------------------------------------------------
module srl_delay_line
    import srl_delay_line_pkg::*;
#(
    parameter  int C_DATA_WIDTH   = 32,
    parameter  int C_NUM_CHANNELS = 1,
    parameter  int C_MAX_DELAY    = 16,
    parameter  int C_RESET_DELAY  = 1,
    localparam int C_DLY_W        = clog2(C_MAX_DELAY + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   ce,
    input  logic                                   cfg_load,
    input  logic [C_DLY_W-1:0]                     delay_cfg,
    output logic                                   cfg_busy,
    output logic                                   cfg_err,
    output logic                                   primed,
    input  logic                                   valid_in,
    input  logic [C_NUM_CHANNELS*C_DATA_WIDTH-1:0] data_in,
    output logic                                   valid_out,
    output logic [C_NUM_CHANNELS*C_DATA_WIDTH-1:0] data_out
);

    localparam int                 DW    = C_NUM_CHANNELS * C_DATA_WIDTH;
    localparam int                 W     = DW + 1;
    localparam logic [C_DLY_W-1:0] MAX_D = C_DLY_W'(C_MAX_DELAY);
    localparam logic [C_DLY_W-1:0] RST_D = C_DLY_W'(C_RESET_DELAY);
    localparam logic [C_DLY_W-1:0] ONE   = C_DLY_W'(1);

    state_t             state;
    logic [C_DLY_W-1:0] delay_q;
    logic [C_DLY_W-1:0] fill_cnt;
    logic               err_q;
    logic               loading;
    logic               over_max;
    logic [C_DLY_W-1:0] clamped;
    logic               primed_core;
    logic [W-1:0]       tap_q;
    logic [W-1:0]       tap_mux;

    assign loading  = (state == ST_LOAD);
    assign over_max = (delay_cfg > MAX_D);
    assign clamped  = over_max ? MAX_D : delay_cfg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_FILL;
            delay_q  <= RST_D;
            fill_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ST_FILL: begin
                    if (cfg_load) begin
                        state   <= ST_LOAD;
                        delay_q <= clamped;
                        err_q   <= over_max;
                    end else if (delay_q == '0) begin
                        // Zero delay has no history to collect.
                        state <= ST_RUN;
                    end else if (ce) begin
                        if (fill_cnt == delay_q - ONE) begin
                            state <= ST_RUN;
                        end else begin
                            fill_cnt <= fill_cnt + ONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (cfg_load) begin
                        state   <= ST_LOAD;
                        delay_q <= clamped;
                        err_q   <= over_max;
                    end
                end
                ST_LOAD: begin
                    fill_cnt <= '0;
                    state    <= (delay_q == '0) ? ST_RUN : ST_FILL;
                end
                default: begin
                    state <= ST_FILL;
                end
            endcase
        end
    end

    assign cfg_busy    = loading;
    assign cfg_err     = err_q;
    assign primed_core = (state == ST_RUN) || ((state == ST_FILL) && (delay_q == '0));

    // LOAD suppresses the shift and clears valids regardless of ce.
    srl_dyn_tap #(
        .C_WIDTH (W),
        .C_DEPTH (C_MAX_DELAY),
        .C_SEL_W (C_DLY_W)
    ) u_tap (
        .clk         (clk),
        .rst         (rst),
        .shift_en    (ce && !loading),
        .clear_valid (loading),
        .din         ({valid_in, data_in}),
        .sel         (delay_q),
        .dout        (tap_q)
    );

    // Delay 0 bypasses the chain; valid is masked while reconfiguring.
    assign tap_mux = (delay_q == '0) ? {valid_in && !loading, data_in} : tap_q;

`ifdef SRL_DELAY_LINE_OUT_REG_EN
    logic [W-1:0] out_q;
    logic         primed_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q    <= '0;
            primed_q <= 1'b0;
        end else if (loading) begin
            out_q    <= '0;
            primed_q <= 1'b0;
        end else if (ce) begin
            out_q    <= tap_mux;
            primed_q <= primed_core;
        end
    end

    assign valid_out = out_q[W-1];
    assign data_out  = out_q[DW-1:0];
    assign primed    = primed_q;
`else
    assign valid_out = tap_mux[W-1];
    assign data_out  = tap_mux[DW-1:0];
    assign primed    = primed_core;
`endif

endmodule

// File: tb/tb_srl_delay_line.sv
// ---------------------------------------------------------------------------
// tb_srl_delay_line
//   Directed bench for srl_delay_line with default parameters
//   (32-bit data, 1 channel, max delay 16, reset delay 1), default build.
// ---------------------------------------------------------------------------
module tb_srl_delay_line;

    localparam int DW    = 32;
    localparam int DLY_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             ce;
    logic             cfg_load;
    logic [DLY_W-1:0] delay_cfg;
    logic             cfg_busy;
    logic             cfg_err;
    logic             primed;
    logic             valid_in;
    logic [DW-1:0]    data_in;
    logic             valid_out;
    logic [DW-1:0]    data_out;

    int n_checks = 0;
    int n_errors = 0;

    srl_delay_line dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .cfg_load  (cfg_load),
        .delay_cfg (delay_cfg),
        .cfg_busy  (cfg_busy),
        .cfg_err   (cfg_err),
        .primed    (primed),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reconfigure with ce low; checks busy window and clamp error pulse.
    task automatic do_load(input logic [DLY_W-1:0] v);
        cfg_load  = 1'b1;
        delay_cfg = v;
        ce        = 1'b0;
        valid_in  = 1'b0;
        tick();
        cfg_load = 1'b0;
        check_eq("load_busy", 32'(cfg_busy), 32'd1);
        check_eq("load_err", 32'(cfg_err), (v > 5'd16) ? 32'd1 : 32'd0);
        tick();
        check_eq("load_busy_end", 32'(cfg_busy), 32'd0);
        check_eq("load_err_end", 32'(cfg_err), 32'd0);
        check_eq("load_primed", 32'(primed), (v == 5'd0) ? 32'd1 : 32'd0);
    endtask

    // Stream cnt items with ce=1 right after a load; item k shows up d cycles later.
    task automatic stream(input int d, input int cnt, input logic [31:0] base);
        for (int n = 0; n < cnt + d; n++) begin
            ce       = 1'b1;
            valid_in = (n < cnt);
            data_in  = base + 32'(n);
            tick();
            begin
                int  k;
                logic ev;
                k  = n - (d - 1);
                ev = (k >= 0) && (k < cnt);
                check_eq("stream_valid", 32'(valid_out), 32'(ev));
                if (ev) check_eq("stream_data", data_out, base + 32'(k));
                check_eq("stream_primed", 32'(primed), (n >= d - 1) ? 32'd1 : 32'd0);
            end
        end
        valid_in = 1'b0;
        ce       = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        ce        = 1'b0;
        cfg_load  = 1'b0;
        delay_cfg = '0;
        valid_in  = 1'b0;
        data_in   = '0;

        // 1: reset state, then single item at delay 1
        tick();
        check_eq("rst_valid_out", 32'(valid_out), 32'd0);
        check_eq("rst_data_out", data_out, 32'd0);
        check_eq("rst_busy", 32'(cfg_busy), 32'd0);
        check_eq("rst_err", 32'(cfg_err), 32'd0);
        check_eq("rst_primed", 32'(primed), 32'd0);
        rst      = 1'b0;
        ce       = 1'b1;
        valid_in = 1'b1;
        data_in  = 32'hA5;
        tick();
        check_eq("t1_valid", 32'(valid_out), 32'd1);
        check_eq("t1_data", data_out, 32'hA5);
        check_eq("t1_primed", 32'(primed), 32'd1);
        valid_in = 1'b0;
        tick();
        check_eq("t1_valid_drop", 32'(valid_out), 32'd0);

        // 2: delay 5, stream 0..9
        do_load(5'd5);
        stream(5, 10, 32'h0);

        // 3: delay 4 with ce toggling; count only ce-high edges
        do_load(5'd4);
        begin
            int e;
            int idx;
            e   = 0;
            idx = 0;
            for (int i = 0; i < 40 && e < 10; i++) begin
                if (i % 2 == 0) begin
                    ce       = 1'b1;
                    valid_in = (idx < 6);
                    data_in  = 32'h300 + 32'(idx);
                    idx++;
                end else begin
                    ce       = 1'b0;
                    valid_in = 1'b1;
                    data_in  = 32'hDEAD;
                end
                tick();
                if (ce) e++;
                begin
                    int  k;
                    logic ev;
                    k  = e - 4;
                    ev = (k >= 0) && (k < 6);
                    check_eq("t3_valid", 32'(valid_out), 32'(ev));
                    if (ev) check_eq("t3_data", data_out, 32'h300 + 32'(k));
                    check_eq("t3_primed", 32'(primed), (e >= 4) ? 32'd1 : 32'd0);
                end
            end
            check_eq("t3_edges", 32'(e), 32'd10);
            ce       = 1'b0;
            valid_in = 1'b0;
        end

        // 4: out-of-range request clamps to 16
        do_load(5'd31);
        stream(16, 3, 32'h400);

        // 5: load during busy ignored, load during fill restarts
        cfg_load  = 1'b1;
        delay_cfg = 5'd6;
        tick();
        check_eq("t5_busy", 32'(cfg_busy), 32'd1);
        delay_cfg = 5'd2;
        tick();
        cfg_load = 1'b0;
        check_eq("t5_busy_ignored", 32'(cfg_busy), 32'd0);
        check_eq("t5_err_ignored", 32'(cfg_err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            ce       = 1'b1;
            valid_in = 1'b1;
            data_in  = 32'h500 + 32'(i);
            tick();
            check_eq("t5_fill_valid", 32'(valid_out), 32'd0);
            check_eq("t5_fill_primed", 32'(primed), 32'd0);
        end
        cfg_load  = 1'b1;
        delay_cfg = 5'd3;
        data_in   = 32'h5FF;
        tick();
        check_eq("t5_reload_busy", 32'(cfg_busy), 32'd1);
        cfg_load = 1'b0;
        ce       = 1'b0;
        valid_in = 1'b0;
        tick();
        check_eq("t5_flushed_valid", 32'(valid_out), 32'd0);
        check_eq("t5_flushed_primed", 32'(primed), 32'd0);
        stream(3, 4, 32'h600);

        // 6: zero delay pass-through, then reset mid-stream
        cfg_load  = 1'b1;
        delay_cfg = 5'd0;
        ce        = 1'b0;
        valid_in  = 1'b1;
        data_in   = 32'h77;
        tick();
        cfg_load = 1'b0;
        check_eq("t6_busy", 32'(cfg_busy), 32'd1);
        check_eq("t6_masked_valid", 32'(valid_out), 32'd0);
        tick();
        check_eq("t6_primed", 32'(primed), 32'd1);
        check_eq("t6_pass_valid", 32'(valid_out), 32'd1);
        check_eq("t6_pass_data", data_out, 32'h77);
        valid_in = 1'b0;
        #1;
        check_eq("t6_pass_valid_low", 32'(valid_out), 32'd0);
        valid_in = 1'b1;
        data_in  = 32'h55;
        #1;
        check_eq("t6_pass_valid_hi", 32'(valid_out), 32'd1);
        check_eq("t6_pass_data2", data_out, 32'h55);
        ce  = 1'b1;
        rst = 1'b1;
        tick();
        check_eq("t6_rst_valid", 32'(valid_out), 32'd0);
        check_eq("t6_rst_data", data_out, 32'd0);
        check_eq("t6_rst_primed", 32'(primed), 32'd0);
        rst      = 1'b0;
        valid_in = 1'b0;
        ce       = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
